// File: rtl/zynq_btn_pkg.sv
// -----------------------------------------------------------------------------
// zynq_btn_pkg
// Shared constants for the push-button debouncer: default channel count, the
// core clock frequency and the 10 ms debounce window derived from it, plus a
// helper that sizes the per-channel stability counter.
// -----------------------------------------------------------------------------
package zynq_btn_pkg;

  localparam int CORE_CLK_HZ         = 25_000_000;
  localparam int N_BTN_DEF           = 4;
  // 10 ms at the core clock.
  localparam int DEBOUNCE_CYCLES_DEF = CORE_CLK_HZ / 100;

  // The counter only ever holds 0..cycles-1, so $clog2(cycles) bits suffice;
  // never return zero so a 2-cycle window still gets a real register.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/zynq_btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// zynq_btn_debounce_ch
// One push-button channel: 2-flop synchronizer, stability counter, debounced
// level and registered one-cycle rise/fall pulses.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous active-high reset
//   raw_i    in   asynchronous pad level
//   state_o  out  debounced level
//   rise_o   out  one-cycle pulse, the cycle after state_o goes 0->1
//   fall_o   out  one-cycle pulse, the cycle after state_o goes 1->0
// -----------------------------------------------------------------------------
module zynq_btn_debounce_ch
  import zynq_btn_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic RST_BIT         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          state_q, state_d;
  logic          state_prv_q;
  logic          rise_q, fall_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter runs only while the synchronized level disagrees with the
  // accepted state; any agreement (a glitch ending) drops it back to zero.
  // On the last count the new level is accepted and the counter restarts
  // from zero instead of wrapping.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d   = '0;
    state_d = state_q;
    if (sync2_q != state_q) begin
      if (cnt_q == CNT_LAST) begin
        state_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // NOTE: reset is asynchronous and asserted on the sensitivity list; every
  // flop, synchronizer included, gets a defined value so release is clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= RST_BIT;
      sync2_q     <= RST_BIT;
      state_q     <= RST_BIT;
      state_prv_q <= RST_BIT;
      cnt_q       <= '0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // the synchronizer chain depends on this.
      sync1_q     <= raw_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      // state_prv_q lags state_q by one cycle, so the pulses below land in
      // the cycle after the debounced level changes.
      state_prv_q <= state_q;
      rise_q      <= state_q & ~state_prv_q;
      fall_q      <= ~state_q & state_prv_q;
    end
  end

  assign state_o = state_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/zynq_btn_debounce.sv
// -----------------------------------------------------------------------------
// zynq_btn_debounce
// N_BTN independent push-button debouncers with sticky press-event flags and a
// registered interrupt request.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous active-high reset
//   btn_raw      in   [N_BTN] asynchronous pad levels
//   btn_state    out  [N_BTN] debounced levels
//   btn_rise     out  [N_BTN] one-cycle pulse per accepted 0->1 transition
//   btn_fall     out  [N_BTN] one-cycle pulse per accepted 1->0 transition
//   evt_clr      in   [N_BTN] per-channel clear of pending press events
//   irq_en       in   [N_BTN] per-channel interrupt enable
//   evt_pending  out  [N_BTN] sticky press-event flags
//   irq          out  registered OR of (evt_pending & irq_en)
// -----------------------------------------------------------------------------
module zynq_btn_debounce
  import zynq_btn_pkg::*;
#(
  parameter int               N_BTN           = N_BTN_DEF,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [N_BTN-1:0] RST_VAL         = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  input  logic [N_BTN-1:0] evt_clr,
  input  logic [N_BTN-1:0] irq_en,
  output logic [N_BTN-1:0] evt_pending,
  output logic             irq
);

  logic [N_BTN-1:0] pending_q, pending_d;
  logic             irq_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    zynq_btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_BIT         (RST_VAL[i])
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn_raw[i]),
      .state_o (btn_state[i]),
      .rise_o  (btn_rise[i]),
      .fall_o  (btn_fall[i])
    );
  end

  // A press arriving in the same cycle as its clear must not be lost, so the
  // set term is OR-ed in after the clear is applied.
  always_comb begin
    pending_d = (pending_q & ~evt_clr) | btn_rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      irq_q     <= |(pending_q & irq_en);
    end
  end

  assign evt_pending = pending_q;
  assign irq         = irq_q;

endmodule
